zhyperram_bus_arbiter: RTL and testbench
========================================

# zhyperram_bus_arbiter

Decides which side owns the shared HyperRAM pins: the IR FPGA write path or the local read sequencer. It filters the IR FPGA's frame-write handshake and grants the bus to the local reader only while the external side is idle. It inserts turnaround gaps on every ownership change and enforces the 2 µs maximum CE-low time on local bursts. Its outputs drive the ADQ/CLK/CE mux select and gate the reader state machine in the route top level.

## Interface
- FILTER_LEN, 20, consecutive synchronized-high cycles before iWr_Req/iWr_Done count as asserted (1..255)
- TURN_GAP, 4, idle cycles inserted on each ownership change (1..255)
- CE_MAX, 96, maximum local CE-low cycles (2 µs at 48 MHz) before forced abort (2..65535)
- iClk  input  1  system clock, 48 MHz HSOSC
- iRst  input  1  synchronous, active-high reset
- iWr_Req  input  1  IR FPGA write request (asynchronous level)
- iWr_Done  input  1  IR FPGA frame-write done (asynchronous level)
- iRAM_CE  input  1  IR FPGA CE, monitored only (asynchronous, low = active)
- iRd_Req  input  1  local reader requests the bus (level, held until granted or withdrawn)
- iRd_Release  input  1  local reader single-cycle pulse: transaction finished
- iLocal_CE  input  1  local reader CE (low = active)
- oWhichWr  output  1  mux select: 0 = IR FPGA, 1 = local
- oRd_Grant  output  1  local reader may drive the bus
- oForce_CE_High  output  1  overrides local CE to high
- oCE_Abort  output  1  one-cycle pulse: local burst killed by CE watchdog
- oFrame_Done  output  1  one-cycle pulse: external frame write completed
- oFrame_Cnt  output  8  completed external frames, wraps 255→0
- oWr_Pending  output  1  filtered write request seen while local owns the bus
- oState  output  3  current state encoding, for debug

## Operation
- Synchronize iWr_Req, iWr_Done, and iRAM_CE through 2 flops each. iRAM_CE sync flops reset to 1.
- Filters: each of req_f and done_f has an 8-bit counter.
  - The counter increments while the synced input is high and saturates at FILTER_LEN.
  - The filtered signal is 1 when the counter equals FILTER_LEN.
  - A synced low clears the counter and the filtered signal on the same edge.
- States (oState): EXT_IDLE=0, EXT_WRITE=1, GAP_TO_LOC=2, LOC_OWN=3, GAP_TO_EXT=4.
- EXT_IDLE (oWhichWr=0)
  - If req_f=1, go to EXT_WRITE. The external side has priority when req_f and iRd_Req are high together.
  - Else if iRd_Req=1 and synced CE=1, go to GAP_TO_LOC.
- EXT_WRITE (oWhichWr=0)
  - If done_f=1 and synced CE=1: pulse oFrame_Done, increment oFrame_Cnt, go to EXT_IDLE.
  - No timeout; the state is held indefinitely.
- GAP_TO_LOC (oWhichWr=1, oForce_CE_High=1, gap counter runs)
  - After TURN_GAP cycles, go to LOC_OWN.
  - If req_f=1 during the gap, return to EXT_IDLE; no grant is issued.
  - If iRd_Req drops during the gap, go to GAP_TO_EXT.
- LOC_OWN (oWhichWr=1, oRd_Grant=1, oForce_CE_High=0)
  - Exit to GAP_TO_EXT on iRd_Release=1, on iRd_Req=0, or on watchdog expiry.
  - req_f=1 sets oWr_Pending. The local transaction is not preempted.
- Watchdog
  - 16-bit counter. It increments each LOC_OWN cycle with iLocal_CE=0 and clears when iLocal_CE=1 or the state is not LOC_OWN.
  - When the count reaches CE_MAX: pulse oCE_Abort, go to GAP_TO_EXT.
  - If iRd_Release arrives on the same cycle, the exit is a normal release: no oCE_Abort.
- GAP_TO_EXT (oWhichWr=1, oRd_Grant=0, oForce_CE_High=1)
  - After TURN_GAP cycles, go to EXT_IDLE and clear oWr_Pending.

## Timing
- Reset values: oWhichWr=0, oRd_Grant=0, oForce_CE_High=1, oCE_Abort=0, oFrame_Done=0, oFrame_Cnt=0, oWr_Pending=0, oState=0. Filters, gap counter and watchdog are cleared.
- iRst asserted in any state returns everything to reset values at the next edge, mid-burst included.
- All outputs are registered.
- Filter latency: req_f rises FILTER_LEN+2 cycles after the first iWr_Req high sampled at an edge.
- Grant latency from EXT_IDLE:
  - oWhichWr=1 on the edge after iRd_Req is sampled high.
  - oRd_Grant=1 exactly TURN_GAP cycles later.
- Grant drop: oRd_Grant=0 and oForce_CE_High=1 on the edge that samples iRd_Release=1 or the watchdog reaching CE_MAX.
- oWhichWr returns to 0 TURN_GAP cycles after the grant drops.
- oFrame_Done and oCE_Abort are always exactly 1 cycle wide.

## Test plan
- Reset, iRd_Req=1, iRAM_CE=1, iWr_Req=0 -> oWhichWr=1 after 1 cycle, oRd_Grant=1 after 5 cycles; iRd_Release pulse -> grant 0 next edge, oWhichWr=0 4 cycles later.
- iWr_Req high 19 cycles then low -> no EXT_WRITE (oState stays 0). Held 22 cycles -> oState=1.
- In EXT_WRITE: iWr_Done high 25 cycles with iRAM_CE=1 -> single oFrame_Done pulse, oFrame_Cnt=1. Repeat 256 frames -> oFrame_Cnt wraps to 0.
- In LOC_OWN, hold iLocal_CE=0 for 96 cycles -> oCE_Abort pulse on the 96th, grant 0, oForce_CE_High=1. Same with iRd_Release on that cycle -> no oCE_Abort.
- iWr_Req filtered during LOC_OWN -> oWr_Pending=1, grant held until iRd_Release, then EXT_IDLE followed by EXT_WRITE.
- Simultaneous iRd_Req and filtered req_f in EXT_IDLE -> EXT_WRITE, no grant. iRst pulse mid-LOC_OWN -> all outputs at reset values next edge.

Source files
------------

// File: rtl/zhyperram_bus_arbiter.sv
// Shared HyperRAM pin arbiter: external IR FPGA write path vs. local read sequencer.
// Filters the external handshake, inserts turnaround gaps and enforces the local CE-low limit.
module zhyperram_bus_arbiter #(
    parameter int unsigned FILTER_LEN = 20,
    parameter int unsigned TURN_GAP   = 4,
    parameter int unsigned CE_MAX     = 96
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iWr_Req,
    input  logic       iWr_Done,
    input  logic       iRAM_CE,
    input  logic       iRd_Req,
    input  logic       iRd_Release,
    input  logic       iLocal_CE,
    output logic       oWhichWr,
    output logic       oRd_Grant,
    output logic       oForce_CE_High,
    output logic       oCE_Abort,
    output logic       oFrame_Done,
    output logic [7:0] oFrame_Cnt,
    output logic       oWr_Pending,
    output logic [2:0] oState
);

    localparam int unsigned FW = 8;
    localparam int unsigned GW = 8;
    localparam int unsigned WW = 16;
    localparam int unsigned CW = 8;

    localparam logic [FW-1:0] FILT_FULL = FW'(FILTER_LEN);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TURN_GAP - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(CE_MAX - 1);

    typedef enum logic [2:0] {
        EXT_IDLE   = 3'd0,
        EXT_WRITE  = 3'd1,
        GAP_TO_LOC = 3'd2,
        LOC_OWN    = 3'd3,
        GAP_TO_EXT = 3'd4
    } state_e;

    logic [1:0]    req_sync_q, done_sync_q, ce_sync_q;
    logic          req_s, done_s, ce_s;
    logic [FW-1:0] req_cnt_q, req_cnt_d, done_cnt_q, done_cnt_d;
    logic          req_f, done_f;

    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          wd_hit;

    logic          whichwr_q, whichwr_d;
    logic          grant_q, grant_d;
    logic          force_q, force_d;
    logic          abort_q, abort_d;
    logic          frame_done_q, frame_done_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          pend_q, pend_d;

    assign req_s  = req_sync_q[1];
    assign done_s = done_sync_q[1];
    assign ce_s   = ce_sync_q[1];

    // Glitch filters: a synced low clears at once, so the filtered level drops with it.
    always_comb begin
        req_cnt_d  = '0;
        done_cnt_d = '0;
        if (req_s) begin
            req_cnt_d = (req_cnt_q == FILT_FULL) ? req_cnt_q : req_cnt_q + FW'(1);
        end
        if (done_s) begin
            done_cnt_d = (done_cnt_q == FILT_FULL) ? done_cnt_q : done_cnt_q + FW'(1);
        end
    end

    assign req_f  = (req_cnt_q == FILT_FULL);
    assign done_f = (done_cnt_q == FILT_FULL);

    always_comb begin
        state_d      = state_q;
        gap_d        = '0;
        wd_d         = '0;
        wd_hit       = 1'b0;
        abort_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        pend_d       = pend_q;

        case (state_q)
            EXT_IDLE: begin
                if (req_f) begin
                    state_d = EXT_WRITE;
                end else if (iRd_Req && ce_s) begin
                    state_d = GAP_TO_LOC;
                end
            end
            EXT_WRITE: begin
                if (done_f && ce_s) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + CW'(1);
                    state_d      = EXT_IDLE;
                end
            end
            GAP_TO_LOC: begin
                // External request wins the gap outright; the local side never saw a grant.
                if (req_f) begin
                    state_d = EXT_IDLE;
                end else if (!iRd_Req) begin
                    state_d = GAP_TO_EXT;
                end else if (gap_q == GAP_LAST) begin
                    state_d = LOC_OWN;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            LOC_OWN: begin
                if (req_f) begin
                    pend_d = 1'b1;
                end
                if (!iLocal_CE) begin
                    wd_d   = wd_q + WW'(1);
                    wd_hit = (wd_q == WD_LAST);
                end
                if (iRd_Release || !iRd_Req || wd_hit) begin
                    state_d = GAP_TO_EXT;
                    wd_d    = '0;
                    abort_d = wd_hit && !iRd_Release;
                end
            end
            GAP_TO_EXT: begin
                if (gap_q == GAP_LAST) begin
                    state_d = EXT_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = EXT_IDLE;
            end
        endcase

        whichwr_d = (state_d == GAP_TO_LOC) || (state_d == LOC_OWN) || (state_d == GAP_TO_EXT);
        grant_d   = (state_d == LOC_OWN);
        force_d   = (state_d != LOC_OWN);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            req_sync_q   <= '0;
            done_sync_q  <= '0;
            ce_sync_q    <= 2'b11;
            req_cnt_q    <= '0;
            done_cnt_q   <= '0;
            state_q      <= EXT_IDLE;
            gap_q        <= '0;
            wd_q         <= '0;
            whichwr_q    <= 1'b0;
            grant_q      <= 1'b0;
            force_q      <= 1'b1;
            abort_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            pend_q       <= 1'b0;
        end else begin
            req_sync_q   <= {req_sync_q[0], iWr_Req};
            done_sync_q  <= {done_sync_q[0], iWr_Done};
            ce_sync_q    <= {ce_sync_q[0], iRAM_CE};
            req_cnt_q    <= req_cnt_d;
            done_cnt_q   <= done_cnt_d;
            state_q      <= state_d;
            gap_q        <= gap_d;
            wd_q         <= wd_d;
            whichwr_q    <= whichwr_d;
            grant_q      <= grant_d;
            force_q      <= force_d;
            abort_q      <= abort_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            pend_q       <= pend_d;
        end
    end

    assign oWhichWr       = whichwr_q;
    assign oRd_Grant      = grant_q;
    assign oForce_CE_High = force_q;
    assign oCE_Abort      = abort_q;
    assign oFrame_Done    = frame_done_q;
    assign oFrame_Cnt     = frame_cnt_q;
    assign oWr_Pending    = pend_q;
    assign oState         = state_q;

endmodule

// File: tb/tb_zhyperram_bus_arbiter.sv
// Bench for zhyperram_bus_arbiter: cycle-accurate reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_zhyperram_bus_arbiter;

    localparam int FL = 20;
    localparam int TG = 4;
    localparam int CM = 96;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iWr_Req = 1'b0;
    logic       iWr_Done = 1'b0;
    logic       iRAM_CE = 1'b1;
    logic       iRd_Req = 1'b0;
    logic       iRd_Release = 1'b0;
    logic       iLocal_CE = 1'b1;
    logic       oWhichWr, oRd_Grant, oForce_CE_High, oCE_Abort, oFrame_Done, oWr_Pending;
    logic [7:0] oFrame_Cnt;
    logic [2:0] oState;

    int n_chk = 0;
    int n_err = 0;

    zhyperram_bus_arbiter #(.FILTER_LEN(FL), .TURN_GAP(TG), .CE_MAX(CM)) dut (
        .iClk(iClk), .iRst(iRst), .iWr_Req(iWr_Req), .iWr_Done(iWr_Done),
        .iRAM_CE(iRAM_CE), .iRd_Req(iRd_Req), .iRd_Release(iRd_Release),
        .iLocal_CE(iLocal_CE), .oWhichWr(oWhichWr), .oRd_Grant(oRd_Grant),
        .oForce_CE_High(oForce_CE_High), .oCE_Abort(oCE_Abort),
        .oFrame_Done(oFrame_Done), .oFrame_Cnt(oFrame_Cnt),
        .oWr_Pending(oWr_Pending), .oState(oState)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: ownership mode with countdown gap timers and run-length filters.
    int mode = 0;
    int gap_left = 0;
    int low_run = 0;
    int req_run = 0, done_run = 0;
    bit req_p1 = 0, req_p2 = 0, done_p1 = 0, done_p2 = 0, ce_p1 = 1, ce_p2 = 1;
    bit m_done = 0, m_abort = 0, m_pend = 0;
    int m_cnt = 0;

    always @(posedge iClk) begin
        bit rf, df;
        int nm;
        if (iRst) begin
            mode = 0; gap_left = 0; low_run = 0; req_run = 0; done_run = 0;
            req_p1 = 0; req_p2 = 0; done_p1 = 0; done_p2 = 0; ce_p1 = 1; ce_p2 = 1;
            m_done = 0; m_abort = 0; m_pend = 0; m_cnt = 0;
        end else begin
            rf = (req_run >= FL);
            df = (done_run >= FL);
            nm = mode;
            m_done = 0;
            m_abort = 0;
            case (mode)
                0: if (rf) nm = 1;
                   else if (iRd_Req && ce_p2) begin nm = 2; gap_left = TG; end
                1: if (df && ce_p2) begin m_done = 1; m_cnt = (m_cnt + 1) % 256; nm = 0; end
                2: if (rf) nm = 0;
                   else if (!iRd_Req) begin nm = 4; gap_left = TG; end
                   else begin gap_left--; if (gap_left == 0) nm = 3; end
                3: begin
                    int low;
                    bit expire;
                    if (rf) m_pend = 1;
                    low = iLocal_CE ? 0 : low_run + 1;
                    expire = (low >= CM);
                    if (iRd_Release || !iRd_Req || expire) begin
                        m_abort = expire && !iRd_Release;
                        nm = 4; gap_left = TG; low_run = 0;
                    end else low_run = low;
                end
                default: begin gap_left--; if (gap_left == 0) begin nm = 0; m_pend = 0; end end
            endcase
            mode = nm;
            req_run  = req_p2  ? ((req_run < FL) ? req_run + 1 : FL) : 0;
            done_run = done_p2 ? ((done_run < FL) ? done_run + 1 : FL) : 0;
            req_p2 = req_p1;   req_p1 = iWr_Req;
            done_p2 = done_p1; done_p1 = iWr_Done;
            ce_p2 = ce_p1;     ce_p1 = iRAM_CE;
        end
    end

    always @(negedge iClk) begin
        chk("state", int'(oState), mode);
        chk("whichwr", int'(oWhichWr), int'(mode >= 2));
        chk("grant", int'(oRd_Grant), int'(mode == 3));
        chk("force_ce", int'(oForce_CE_High), int'(mode != 3));
        chk("ce_abort", int'(oCE_Abort), int'(m_abort));
        chk("frame_done", int'(oFrame_Done), int'(m_done));
        chk("frame_cnt", int'(oFrame_Cnt), m_cnt);
        chk("wr_pending", int'(oWr_Pending), int'(m_pend));
    end

    task automatic step(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic do_frame();
        iWr_Req = 1; step(23);
        iWr_Req = 0; iWr_Done = 1; step(23);
        iWr_Done = 0; step(3);
    endtask

    initial begin
        int pulses;
        step(3);
        chk("rst_state", int'(oState), 0);
        chk("rst_force", int'(oForce_CE_High), 1);
        chk("rst_cnt", int'(oFrame_Cnt), 0);
        iRst = 0; step(2);

        // Local grant and release
        iRd_Req = 1; step(1);
        chk("t1_whichwr_1", int'(oWhichWr), 1);
        chk("t1_grant_early", int'(oRd_Grant), 0);
        step(3);
        chk("t1_grant_gap", int'(oRd_Grant), 0);
        step(1);
        chk("t1_grant_5", int'(oRd_Grant), 1);
        iRd_Release = 1; step(1);
        iRd_Release = 0; iRd_Req = 0;
        chk("t1_grant_drop", int'(oRd_Grant), 0);
        chk("t1_force", int'(oForce_CE_High), 1);
        step(3);
        chk("t1_whichwr_held", int'(oWhichWr), 1);
        step(1);
        chk("t1_whichwr_back", int'(oWhichWr), 0);
        step(2);

        // Request withdrawn during gap
        iRd_Req = 1; step(2); iRd_Req = 0; step(8);

        // Filter: 19 cycles too short, sustained request wins
        iWr_Req = 1; step(19); iWr_Req = 0; step(25);
        chk("t2_short_req", int'(oState), 0);
        iWr_Req = 1; step(22);
        chk("t2_req_22", int'(oState), 0);
        step(1);
        chk("t2_ext_write", int'(oState), 1);

        // Frame completion: single pulse
        iWr_Req = 0; iWr_Done = 1; pulses = 0;
        for (int i = 0; i < 25; i++) begin step(1); pulses += int'(oFrame_Done); end
        chk("t3_single_pulse", pulses, 1);
        chk("t3_cnt_1", int'(oFrame_Cnt), 1);
        iWr_Done = 0; step(4);
        for (int f = 0; f < 255; f++) do_frame();
        chk("t3_cnt_wrap", int'(oFrame_Cnt), 0);

        // Watchdog abort
        iRd_Req = 1; step(5);
        chk("t4_own", int'(oState), 3);
        iLocal_CE = 0; step(95);
        chk("t4_no_abort_95", int'(oCE_Abort), 0);
        chk("t4_grant_95", int'(oRd_Grant), 1);
        step(1);
        chk("t4_abort", int'(oCE_Abort), 1);
        chk("t4_grant_off", int'(oRd_Grant), 0);
        chk("t4_force", int'(oForce_CE_High), 1);
        step(1);
        chk("t4_abort_width", int'(oCE_Abort), 0);
        iLocal_CE = 1; iRd_Req = 0; step(6);

        // Watchdog expiry coinciding with release
        iRd_Req = 1; step(5);
        iLocal_CE = 0; step(95);
        iRd_Release = 1; step(1);
        iRd_Release = 0; iRd_Req = 0; iLocal_CE = 1;
        chk("t4_rel_no_abort", int'(oCE_Abort), 0);
        chk("t4_rel_grant", int'(oRd_Grant), 0);
        step(6);

        // External request pending during local ownership
        iRd_Req = 1; step(5);
        iWr_Req = 1; step(25);
        chk("t5_pending", int'(oWr_Pending), 1);
        chk("t5_grant_held", int'(oRd_Grant), 1);
        iRd_Release = 1; step(1);
        iRd_Release = 0; iRd_Req = 0;
        step(4);
        chk("t5_idle", int'(oState), 0);
        chk("t5_pend_clr", int'(oWr_Pending), 0);
        step(1);
        chk("t5_write", int'(oState), 1);
        iWr_Req = 0; iWr_Done = 1; step(25); iWr_Done = 0; step(5);

        // Simultaneous local and filtered external request
        iWr_Req = 1; step(22);
        iRd_Req = 1; step(1);
        chk("t6_ext_prio", int'(oState), 1);
        chk("t6_no_grant", int'(oRd_Grant), 0);
        iRd_Req = 0; iWr_Req = 0; iWr_Done = 1; step(25); iWr_Done = 0; step(5);

        // Filtered request arriving inside the gap to local
        iWr_Req = 1; step(21);
        iRd_Req = 1; step(1);
        chk("t6_gap_entered", int'(oState), 2);
        step(1);
        chk("t6_gap_abandon", int'(oState), 0);
        iRd_Req = 0; iWr_Req = 0; iWr_Done = 1; step(25); iWr_Done = 0; step(5);
        chk("t6_cnt", int'(oFrame_Cnt), 3);

        // Reset in the middle of a local burst
        iRd_Req = 1; step(5);
        iLocal_CE = 0; step(10);
        iRst = 1; step(1);
        chk("t7_state", int'(oState), 0);
        chk("t7_grant", int'(oRd_Grant), 0);
        chk("t7_whichwr", int'(oWhichWr), 0);
        chk("t7_force", int'(oForce_CE_High), 1);
        chk("t7_cnt", int'(oFrame_Cnt), 0);
        iRst = 0; iRd_Req = 0; iLocal_CE = 1; step(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
